// File: rtl/lens_filter_pkg.sv
// Shared constants and helpers for the lens-filter board input conditioning.
// DEBOUNCE_10MS_100MHZ and LONG_PRESS_500MS_100MHZ are the production
// overrides for multi_channel_debounce_edge at a 100 MHz system clock.
// cnt_width() sizes a counter that must hold 0..max_val. It never
// returns a zero width, so a feature disabled with a count of 0 still
// elaborates cleanly.
package lens_filter_pkg;

  localparam int DEBOUNCE_10MS_100MHZ    = 1_000_000;
  localparam int LONG_PRESS_500MS_100MHZ = 50_000_000;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input-conditioning channel. It synchronises an asynchronous input,
// debounces it, and produces registered edge and long-press pulses.
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   sig        in   raw asynchronous input
//   level      out  debounced level
//   rise       out  1-cycle pulse when level goes 0->1
//   fall       out  1-cycle pulse when level goes 1->0
//   long_press out  1-cycle pulse once level has been high LONG_PRESS_CYCLES
module debounce_channel
  import lens_filter_pkg::*;
#(
  parameter int   SYNC_STAGES       = 2,
  parameter int   DEBOUNCE_CYCLES   = DEBOUNCE_10MS_100MHZ,
  parameter int   LONG_PRESS_CYCLES = LONG_PRESS_500MS_100MHZ,
  parameter logic RESET_LEVEL       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic level,
  output logic rise,
  output logic fall,
  output logic long_press
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int HW = cnt_width(LONG_PRESS_CYCLES);
  localparam logic [DW-1:0] D_TERM =
    (DEBOUNCE_CYCLES > 0) ? DW'(DEBOUNCE_CYCLES - 1) : '0;
  localparam logic [HW-1:0] L_FULL = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] L_TERM =
    (LONG_PRESS_CYCLES > 0) ? HW'(LONG_PRESS_CYCLES - 1) : '0;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [DW-1:0]          deb_q, deb_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic                   transfer;
  logic                   rise_d, fall_d, lp_d;

  assign sync = sync_q[SYNC_STAGES-1];

  // Debounce: count consecutive cycles where sync disagrees with level.
  // The level follows sync on the DEBOUNCE_CYCLES-th such cycle. Any
  // agreement restarts the count. A count of 0 makes level follow sync
  // directly.
  always_comb begin
    deb_d    = '0;
    transfer = 1'b0;
    if (DEBOUNCE_CYCLES == 0) begin
      transfer = (sync != level);
    end else if (sync != level) begin
      if (deb_q == D_TERM) transfer = 1'b1;
      else                 deb_d    = deb_q + 1'b1;
    end
  end

  assign rise_d = transfer &  sync;
  assign fall_d = transfer & ~sync;

  // Hold counter saturates at LONG_PRESS_CYCLES, so long_press fires once
  // per press. A release landing on the terminal cycle takes priority:
  // it clears the count and suppresses the pulse.
  always_comb begin
    hold_d = hold_q;
    lp_d   = 1'b0;
    if (LONG_PRESS_CYCLES == 0 || !level || fall_d) begin
      hold_d = '0;
    end else if (hold_q != L_FULL) begin
      hold_d = hold_q + 1'b1;
      lp_d   = (hold_q == L_TERM);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= {SYNC_STAGES{RESET_LEVEL}};
      level      <= RESET_LEVEL;
      deb_q      <= '0;
      hold_q     <= '0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      long_press <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], sig};
      deb_q      <= deb_d;
      hold_q     <= hold_d;
      rise       <= rise_d;
      fall       <= fall_d;
      long_press <= lp_d;
      if (transfer) level <= sync;
    end
  end

endmodule

// File: rtl/multi_channel_debounce_edge.sv
// Multi-channel input conditioner for the lens-filter board controls.
// Each channel is an independent debounce_channel instance.
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   sig_in       in   [NUM_CH] raw asynchronous inputs
//   level_out    out  [NUM_CH] debounced levels
//   rising_edge  out  [NUM_CH] 1-cycle pulse on a debounced 0->1
//   falling_edge out  [NUM_CH] 1-cycle pulse on a debounced 1->0
//   long_press   out  [NUM_CH] 1-cycle pulse after LONG_PRESS_CYCLES high
module multi_channel_debounce_edge
  import lens_filter_pkg::*;
#(
  parameter int   NUM_CH            = 4,
  parameter int   SYNC_STAGES       = 2,
  parameter int   DEBOUNCE_CYCLES   = DEBOUNCE_10MS_100MHZ,
  parameter int   LONG_PRESS_CYCLES = LONG_PRESS_500MS_100MHZ,
  parameter logic RESET_LEVEL       = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] sig_in,
  output logic [NUM_CH-1:0] level_out,
  output logic [NUM_CH-1:0] rising_edge,
  output logic [NUM_CH-1:0] falling_edge,
  output logic [NUM_CH-1:0] long_press
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES      (SYNC_STAGES),
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .RESET_LEVEL      (RESET_LEVEL)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .sig       (sig_in[i]),
      .level     (level_out[i]),
      .rise      (rising_edge[i]),
      .fall      (falling_edge[i]),
      .long_press(long_press[i])
    );
  end

endmodule

// File: tb/tb_multi_channel_debounce_edge.sv
// Self-checking bench for multi_channel_debounce_edge. The reference model
// keeps the raw input samples in a queue. A channel's level changes when
// the last D synchronised samples all disagree with it. A long press is
// the L-th edge after a rise with no fall in between.
module tb_multi_channel_debounce_edge;

  localparam int NUM_CH = 4;
  localparam int S      = 2;
  localparam int D      = 4;
  localparam int L      = 10;
  localparam int OW     = 4 * NUM_CH;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] sig_in;
  logic [NUM_CH-1:0] level_out, rising_edge, falling_edge, long_press;

  always #5 clk = ~clk;

  multi_channel_debounce_edge #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D),
    .LONG_PRESS_CYCLES(L), .RESET_LEVEL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .sig_in(sig_in), .level_out(level_out),
    .rising_edge(rising_edge), .falling_edge(falling_edge),
    .long_press(long_press)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] outs();
    return {long_press, falling_edge, rising_edge, level_out};
  endfunction

  // ---------------- reference model / scoreboard ----------------
  logic [NUM_CH-1:0] samp_q[$];
  logic [OW-1:0]     exp_q[$];
  logic [NUM_CH-1:0] m_level;
  int                rise_at[NUM_CH];
  int                edge_n;

  always @(posedge clk) begin
    logic [NUM_CH-1:0] e_rise, e_fall, e_lp;
    bit tr;
    if (reset) begin
      samp_q.delete();
      for (int i = 0; i < S + D; i++) samp_q.push_back('0);
      m_level = '0;
      for (int c = 0; c < NUM_CH; c++) rise_at[c] = -1;
      edge_n = 0;
      exp_q.push_back('0);
    end else begin
      edge_n++;
      samp_q.push_back(sig_in);
      if (samp_q.size() > S + D) void'(samp_q.pop_front());
      // samp_q[0..D-1] are the synchronised values seen over the last D edges
      e_rise = '0; e_fall = '0; e_lp = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        tr = 1'b1;
        for (int j = 0; j < D; j++)
          if (samp_q[j][c] == m_level[c]) tr = 1'b0;
        if (tr) begin
          e_rise[c] = ~m_level[c];
          e_fall[c] =  m_level[c];
        end
        if (m_level[c] && !e_fall[c] && rise_at[c] >= 0 &&
            edge_n - rise_at[c] == L)
          e_lp[c] = 1'b1;
        if (e_rise[c]) rise_at[c] = edge_n;
        if (e_fall[c]) rise_at[c] = -1;
        if (tr) m_level[c] = ~m_level[c];
      end
      exp_q.push_back({e_lp, e_fall, e_rise, m_level});
    end
  end

  always @(negedge clk) begin
    logic [OW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("model_outs", outs(), e);
      check_eq("rise_fall_excl", rising_edge & falling_edge, '0);
    end
  end

  // ---------------- driver tasks ----------------
  // Counts negedges until the selected output bit goes high, capped at lim.
  task automatic wait_bit(input int sel, input int ch, input int lim,
                          output int k);
    logic b;
    k = 0;
    while (k < lim) begin
      @(negedge clk);
      k++;
      case (sel)
        0:       b = level_out[ch];
        1:       b = rising_edge[ch];
        2:       b = falling_edge[ch];
        default: b = long_press[ch];
      endcase
      if (b) break;
    end
  endtask

  task automatic pulse_reset(input int cycles);
    #2 reset = 1'b1;
    #1 check_eq("rst_async_outs", outs(), '0);
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k, lp_cnt, rate;
    logic seen;
    sig_in = '0;
    reset  = 1'b1;
    #1 check_eq("rst_outs", outs(), '0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // 1: clean step on ch0
    sig_in[0] = 1'b1;
    wait_bit(0, 0, 20, k);
    check_eq("lat_rise_ch0", k, 6);
    check_eq("rise_ch0", rising_edge[0], 1);
    @(negedge clk);
    check_eq("rise_ch0_len", rising_edge[0], 0);

    // 2: 3-cycle glitch on ch1
    seen = 1'b0;
    sig_in[1] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      seen |= level_out[1] | rising_edge[1] | falling_edge[1] | long_press[1];
    end
    sig_in[1] = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen |= level_out[1] | rising_edge[1] | falling_edge[1] | long_press[1];
    end
    check_eq("glitch_ch1", seen, 0);

    // 3: long press on ch2
    sig_in[2] = 1'b1;
    wait_bit(1, 2, 20, k);
    check_eq("lat_rise_ch2", k, 6);
    wait_bit(3, 2, 30, k);
    check_eq("lp_delay_ch2", k, 10);
    lp_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      lp_cnt += int'(long_press[2]);
    end
    check_eq("lp_no_repeat", lp_cnt, 0);

    // 4: release then re-press ch2
    sig_in[2] = 1'b0;
    wait_bit(2, 2, 20, k);
    check_eq("lat_fall_ch2", k, 6);
    repeat (4) @(negedge clk);
    sig_in[2] = 1'b1;
    wait_bit(1, 2, 20, k);
    check_eq("lat_rerise_ch2", k, 6);
    wait_bit(3, 2, 30, k);
    check_eq("lp_rearm_ch2", k, 10);

    // 5: reset mid-debounce on ch3
    sig_in[3] = 1'b1;
    repeat (3) @(negedge clk);
    pulse_reset(2);
    wait_bit(1, 3, 20, k);
    check_eq("lat_after_rst_ch3", k, 6);

    // 6: all channels step together
    sig_in = '0;
    repeat (12) @(negedge clk);
    check_eq("all_low", level_out, 0);
    sig_in = '1;
    repeat (5) @(negedge clk);
    check_eq("all_rise_early", rising_edge, 0);
    @(negedge clk);
    check_eq("all_rise", rising_edge, 4'hF);
    check_eq("all_level", level_out, 4'hF);

    // random phase: blocks of varying toggle rate, occasional reset
    for (int b = 0; b < 20; b++) begin
      rate = $urandom_range(2, 40);
      repeat (200) begin
        @(negedge clk);
        for (int c = 0; c < NUM_CH; c++)
          if ($urandom_range(0, rate - 1) == 0) sig_in[c] = ~sig_in[c];
        if ($urandom_range(0, 699) == 0) pulse_reset($urandom_range(1, 3));
      end
    end

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
